// File: rtl/din_debounce_counter.sv
// Synchronizes din, debounces it with a consecutive-sample FSM, emits edge strobes and a
// saturating rising-edge count. Optional sticky irq flag is enabled by DIN_DEBOUNCE_IRQ_EN.
module din_debounce_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 3,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             dout,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_sat,
    output logic             irq,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK} state_t;

    localparam int FW = $clog2(STABLE_CYC + 1);
    localparam logic [FW:0] STABLE_V = (FW + 1)'(STABLE_CYC);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic [FW:0]            fcnt_inc;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_base;
    logic                   sat_q, sat_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        fcnt_inc = {1'b0, fcnt_q} + 1'b1;
        case (state_q)
            S_LOW: begin
                if (s) begin
                    if (STABLE_CYC == 1) begin
                        state_d = S_HIGH;
                    end else begin
                        state_d = S_RISE_CHK;
                        fcnt_d  = FW'(1);
                    end
                end
            end
            S_RISE_CHK: begin
                if (!s) begin
                    state_d = S_LOW;
                    fcnt_d  = '0;
                end else if (fcnt_inc == STABLE_V) begin
                    state_d = S_HIGH;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_inc[FW-1:0];
                end
            end
            S_HIGH: begin
                if (!s) begin
                    if (STABLE_CYC == 1) begin
                        state_d = S_LOW;
                    end else begin
                        state_d = S_FALL_CHK;
                        fcnt_d  = FW'(1);
                    end
                end
            end
            default: begin
                if (s) begin
                    state_d = S_HIGH;
                    fcnt_d  = '0;
                end else if (fcnt_inc == STABLE_V) begin
                    state_d = S_LOW;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_inc[FW-1:0];
                end
            end
        endcase
    end

    // Pulses fire only on genuine level changes; rejected glitches return to the old level silently.
    always_comb begin
        dout_d = (state_d == S_HIGH) || (state_d == S_FALL_CHK);
        rise_d = (state_d == S_HIGH) && !((state_q == S_HIGH) || (state_q == S_FALL_CHK));
        fall_d = (state_d == S_LOW) && ((state_q == S_HIGH) || (state_q == S_FALL_CHK));
    end

    // Clear is applied before the increment so a coincident pulse still counts.
    always_comb begin
        cnt_base = clr_cnt ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (rise_q && (cnt_base != '1)) begin
            cnt_d = cnt_base + 1'b1;
        end
        sat_d = (sat_q && !clr_cnt) || (&cnt_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= S_LOW;
            fcnt_q  <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

`ifdef DIN_DEBOUNCE_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = (irq_q && !clr_cnt) || rise_q || fall_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign dout       = dout_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign edge_cnt   = cnt_q;
    assign cnt_sat    = sat_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/din_debounce_counter.md
Name: din_debounce_counter

Overview:
Downstream consumer of a single-bit registered stream, such as the `out` of a flop stage. Synchronizes the bit and glitch-filters it with a consecutive-sample debouncer FSM. Emits clean level and one-cycle edge strobes, and keeps a saturating count of rising edges. Results are available for status readout and for downstream event logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on din (>=2).
- STABLE_CYC, 3, consecutive equal synchronized samples required to accept a level change (>=1).
- CNT_W, 8, width of the rising-edge counter (>=2).

Ports:
- clk  input  1  single rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- din  input  1  raw bit stream from the upstream flop stage.
- clr_cnt  input  1  synchronous clear of edge_cnt, cnt_sat (and irq when enabled).
- dout  output  1  debounced level.
- rise_pulse  output  1  one-cycle strobe on accepted 0->1.
- fall_pulse  output  1  one-cycle strobe on accepted 1->0.
- edge_cnt  output  CNT_W  count of accepted rising edges.
- cnt_sat  output  1  sticky; edge_cnt reached all-ones.
- irq  output  1  sticky event flag (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous)
  - Synchronizer flops, dout, rise_pulse, fall_pulse, edge_cnt, cnt_sat and irq all go to 0.
  - FSM goes to S_LOW and the filter counter fcnt goes to 0.
  - Reset asserted mid-filter discards the partial count. No pulse is produced on reset release.
- Synchronizer: din passes through SYNC_STAGES flops; the last stage is `s`. All logic below uses `s` only.
- FSM states: S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK.
  - S_LOW, s=1:
    - STABLE_CYC=1: go to S_HIGH.
    - Otherwise: go to S_RISE_CHK with fcnt=1.
  - S_RISE_CHK, s=1:
    - fcnt+1 < STABLE_CYC: increment fcnt.
    - fcnt+1 == STABLE_CYC: go to S_HIGH.
  - S_RISE_CHK, s=0: glitch rejected; go to S_LOW with fcnt=0 and no pulse.
  - S_HIGH and S_FALL_CHK mirror the above with s=0 as the candidate level.
- Outputs
  - On entry to S_HIGH: dout=1 and rise_pulse=1 for exactly that cycle.
  - On entry to S_LOW from S_FALL_CHK: dout=0 and fall_pulse=1 for exactly that cycle.
  - dout is registered and equals 1 exactly in S_HIGH and S_FALL_CHK.
- Latency
  - If din is first sampled at its new level at edge k and then held, dout changes after edge k+SYNC_STAGES+STABLE_CYC-1. With defaults that is 4 edges.
  - A pulse held for fewer than STABLE_CYC synchronized cycles produces no dout change.
- Counter
  - Increments by 1 on each rise_pulse.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat is set in the cycle edge_cnt becomes all-ones and stays set until clr_cnt or reset.
  - clr_cnt together with rise_pulse in the same cycle: clear first, then count, giving edge_cnt=1 and cnt_sat=0.
  - clr_cnt never affects the FSM, dout or the pulse outputs.
- rise_pulse and fall_pulse are never high in the same cycle.

Optional Feature:
- Macro: DIN_DEBOUNCE_IRQ_EN.
- Defined: irq sets to 1 on the edge after any rise_pulse or fall_pulse. It is sticky and cleared by clr_cnt. Simultaneous clr_cnt and pulse leaves irq=1 (set wins).
- Not defined: irq is tied to constant 0 and no irq register exists.

Test Plan:
- Reset release with din=0 for 20 cycles -> dout=0, no pulses, edge_cnt=0.
- din 0->1 held 10 cycles (defaults) -> dout rises exactly 4 edges after first high sample; rise_pulse is one cycle wide; edge_cnt=1.
- din high for 2 cycles, then low (glitch) -> dout stays 0, no rise_pulse, edge_cnt unchanged; the same for a 2-cycle low dip while dout=1 (no fall_pulse).
- CNT_W=2: 4 clean rising edges -> edge_cnt 1,2,3,3 and cnt_sat=1 after the third; clr_cnt on the cycle of the 5th rise_pulse -> edge_cnt=1, cnt_sat=0.
- reset pulsed low while in S_RISE_CHK with fcnt=2 -> all outputs 0 immediately; after release, din must again be held 3 synchronized cycles to set dout.
- With DIN_DEBOUNCE_IRQ_EN defined: one rise then one fall -> irq=1 after the first pulse; clr_cnt -> irq=0. Without the macro, irq=0 throughout.
